eth_scrambler_pipe: RTL and testbench
=====================================

Name: eth_scrambler_pipe

Overview:
- Parametrised 64b/66b self-synchronous scrambler/descrambler using polynomial x^58 + x^39 + 1.
- Sits between the PCS encoder and the TX gearbox (MODE=0), or between the RX block-sync and the decoder (MODE=1).
- Adds over the previous generation:
  - descramble mode;
  - a 2-bit sync-header sideband passed through unscrambled;
  - true valid/ready backpressure with a 2-entry skid buffer;
  - runtime seed load and a state monitor output.

Parameters:
- DATA_WIDTH, 32: payload bits per beat; legal 8..64.
- MODE, 0: 0 = scramble, 1 = descramble.
- RESET_SEED, 58'h3FF_FFFF_FFFF_FFFF: LFSR state after reset.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_bypass  in  1  1 = data passes through unchanged, LFSR frozen
- i_seed_load  in  1  load i_seed into LFSR, one-cycle pulse
- i_seed  in  58  seed value
- i_valid  in  1  upstream beat valid
- o_ready  out  1  block can accept a beat
- i_data  in  DATA_WIDTH  payload, MSB is first on the wire
- i_header  in  2  sync header, meaningful when i_hdr_valid=1
- i_hdr_valid  in  1  this beat starts a 66-bit block
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts
- o_data  out  DATA_WIDTH  processed payload
- o_header  out  2  header, unmodified
- o_hdr_valid  out  1  aligned with o_data
- o_state  out  58  current LFSR state

Behaviour:
- Reset values:
  - o_valid=0, o_ready=1, o_data=0, o_header=0, o_hdr_valid=0.
  - LFSR = RESET_SEED; skid buffer empty.
  - Reset mid-transfer discards both buffered beats.
- Accept:
  - A beat is accepted when i_valid && o_ready.
  - It is emitted on o_* the next cycle if the output register is empty or draining; otherwise it goes to the skid register.
- Output handshake:
  - A beat is taken when o_valid && i_ready.
  - o_data, o_header and o_hdr_valid must hold stable while o_valid && !i_ready.
- Ready:
  - o_ready is registered.
  - o_ready = 1 when the skid register is empty; it deasserts the cycle after the skid fills.
  - No beat is ever dropped or duplicated.
- Latency: 1 cycle when unstalled; full throughput, one beat per cycle.
- Per-bit recurrence, applied per accepted beat, bit k from DATA_WIDTH-1 down to 0:
  - t = s[38] ^ s[57]; out[k] = in[k] ^ t.
  - MODE=0: s = {s[56:0], out[k]}.
  - MODE=1: s = {s[56:0], in[k]}.
  - The state after the beat is committed at accept.
  - Scrambling is computed at accept; the stored beat is final data.
- Header:
  - Never scrambled and never enters the LFSR.
  - Travels with its beat through both registers.
- Bypass:
  - Sampled at accept, per beat.
  - Data is copied unchanged and the LFSR is not advanced.
- Seed load:
  - On i_seed_load, LFSR <= i_seed.
  - Load takes priority over an advance in the same cycle; the beat accepted that cycle is processed with the pre-load state, and the loaded value wins.
  - An all-zero seed is allowed with no special handling.
- o_state equals the LFSR register, i.e. the state that will be used for the next accepted beat.
- Descrambler self-synchronisation: output is correct from the first bit following 58 received bits, regardless of the initial state.

Test Plan:
- Basic scramble:
  - MODE=0, after reset, send 32'h0000_0000 then 32'h0000_0000 with i_ready=1.
  - Required: o_data = 32'h0000_0000, then 32'h01FF_FFC0.
  - o_state after beat 1 = 58'h3FF_FFFF_0000_0000.
  - Each o_valid appears 1 cycle after accept.
- Loopback:
  - MODE=0 instance feeds a MODE=1 instance whose state was seeded to 58'h0.
  - 1000 random beats with random headers.
  - Required: beats from the 3rd onward (≥58 bits received) match the source exactly; headers match on all beats.
- Backpressure:
  - i_valid=1 continuously, i_ready toggled pseudo-randomly at 50%.
  - Required: o_ready deasserts the cycle after the skid fills; no loss or duplication; o_data stable during stall.
  - Output sequence equals the unstalled golden sequence.
- Bypass:
  - Assert i_bypass on beat 2 of 4 with data 32'hDEAD_BEEF.
  - Required: o_data = 32'hDEAD_BEEF for beat 2; o_state unchanged across beat 2.
  - Beats 3-4 equal the golden output of beats 2-3 without bypass.
- Seed load:
  - Pulse i_seed_load with i_seed = 58'h0 while idle, then send 32'hFFFF_FFFF.
  - Required: o_data = 32'hFFFF_FFFF.
  - o_state = 58'h0000_0000_FFFF_FFFF after the beat.
- Reset mid-operation:
  - Stall with both registers full, assert i_rst_n=0 for 1 cycle.
  - Required: o_valid=0 immediately (asynchronous), o_ready=1 after release, o_state = RESET_SEED.

Source files
------------

// File: rtl/eth_scrambler_pipe.sv
// 64b/66b self-synchronous scrambler/descrambler (x^58 + x^39 + 1) with a one-beat
// output register, a one-beat skid register and a sync-header sideband.
module eth_scrambler_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MODE       = 0,
   parameter logic [57:0] RESET_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_bypass,
   input  logic                  i_seed_load,
   input  logic [57:0]           i_seed,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [1:0]            i_header,
   input  logic                  i_hdr_valid,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_header,
   output logic                  o_hdr_valid,
   output logic [57:0]           o_state
);

   // Beat layout: {hdr_valid, header[1:0], data}
   localparam int unsigned BeatW = DATA_WIDTH + 3;

   logic [57:0]           lfsr_q, lfsr_d, lfsr_adv;
   logic [DATA_WIDTH-1:0] scr_data;
   logic [BeatW-1:0]      in_beat;
   logic [BeatW-1:0]      out_beat_q, out_beat_d;
   logic [BeatW-1:0]      skid_beat_q, skid_beat_d;
   logic                  out_valid_q, out_valid_d;
   logic                  skid_valid_q, skid_valid_d;
   logic                  ready_q, ready_d;
   logic                  accept, take;

   // MSB goes first on the wire, so it is processed first.
   always_comb begin
      lfsr_adv = lfsr_q;
      scr_data = '0;
      for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
         scr_data[k] = i_data[k] ^ lfsr_adv[38] ^ lfsr_adv[57];
         lfsr_adv    = {lfsr_adv[56:0], (MODE == 0) ? scr_data[k] : i_data[k]};
      end
   end

   assign in_beat = {i_hdr_valid, i_header, i_bypass ? i_data : scr_data};
   assign accept  = i_valid && ready_q;
   assign take    = out_valid_q && i_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_beat_d   = out_beat_q;
      skid_valid_d = skid_valid_q;
      skid_beat_d  = skid_beat_q;
      if (!out_valid_q || take) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_beat_d   = skid_beat_q;
            skid_valid_d = accept;
            if (accept) begin
               skid_beat_d = in_beat;
            end
         end else begin
            out_valid_d = accept;
            if (accept) begin
               out_beat_d = in_beat;
            end
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_beat_d  = in_beat;
      end
      ready_d = !skid_valid_d;
   end

   // A seed load overrides the advance of a beat accepted in the same cycle.
   always_comb begin
      lfsr_d = lfsr_q;
      if (accept && !i_bypass) begin
         lfsr_d = lfsr_adv;
      end
      if (i_seed_load) begin
         lfsr_d = i_seed;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lfsr_q       <= RESET_SEED;
         out_valid_q  <= 1'b0;
         out_beat_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_beat_q  <= '0;
         ready_q      <= 1'b1;
      end else begin
         lfsr_q       <= lfsr_d;
         out_valid_q  <= out_valid_d;
         out_beat_q   <= out_beat_d;
         skid_valid_q <= skid_valid_d;
         skid_beat_q  <= skid_beat_d;
         ready_q      <= ready_d;
      end
   end

   assign o_ready     = ready_q;
   assign o_valid     = out_valid_q;
   assign o_data      = out_beat_q[DATA_WIDTH-1:0];
   assign o_header    = out_beat_q[DATA_WIDTH+1:DATA_WIDTH];
   assign o_hdr_valid = out_beat_q[DATA_WIDTH+2];
   assign o_state     = lfsr_q;

endmodule

// File: tb/tb_eth_scrambler_pipe.sv
// Bench for eth_scrambler_pipe: a scrambler under test, looped into a descrambler, checked
// against a bit-stream history model and a beat-occupancy model.
module tb_eth_scrambler_pipe;

   localparam logic [57:0] SEED0 = 58'h3FF_FFFF_FFFF_FFFF;

   logic        clk, rst_n;
   logic        i_bypass, i_seed_load, i_valid, i_hdr_valid;
   logic [57:0] i_seed;
   logic [31:0] i_data;
   logic [1:0]  i_header;
   logic        o_ready, o_valid, o_hdr_valid;
   logic [31:0] o_data;
   logic [1:0]  o_header;
   logic [57:0] o_state;
   logic        tb_ready, tx_ready, loop_en;

   logic        rx_seed_load, rx_ready, rx_i_valid, rx_o_ready, rx_o_valid, rx_hv;
   logic [57:0] rx_seed, rx_state;
   logic [31:0] rx_data;
   logic [1:0]  rx_hdr;

   int          n_checks, n_errors;
   logic        hist[$];
   logic [34:0] exp_q[$];
   logic [34:0] src_q[$];
   int          occ, rx_idx;
   logic        mon_en, stall_prev, rand_tx, rand_rx;
   logic [34:0] held;

   assign tx_ready   = loop_en ? rx_o_ready : tb_ready;
   assign rx_i_valid = o_valid && loop_en;

   eth_scrambler_pipe #(.DATA_WIDTH(32), .MODE(0), .RESET_SEED(SEED0)) u_tx (
      .i_clk(clk), .i_rst_n(rst_n), .i_bypass(i_bypass), .i_seed_load(i_seed_load),
      .i_seed(i_seed), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
      .i_header(i_header), .i_hdr_valid(i_hdr_valid), .o_valid(o_valid), .i_ready(tx_ready),
      .o_data(o_data), .o_header(o_header), .o_hdr_valid(o_hdr_valid), .o_state(o_state)
   );

   eth_scrambler_pipe #(.DATA_WIDTH(32), .MODE(1), .RESET_SEED(SEED0)) u_rx (
      .i_clk(clk), .i_rst_n(rst_n), .i_bypass(1'b0), .i_seed_load(rx_seed_load),
      .i_seed(rx_seed), .i_valid(rx_i_valid), .o_ready(rx_o_ready), .i_data(o_data),
      .i_header(o_header), .i_hdr_valid(o_hdr_valid), .o_valid(rx_o_valid), .i_ready(rx_ready),
      .o_data(rx_data), .o_header(rx_hdr), .o_hdr_valid(rx_hv), .o_state(rx_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Reference: scrambled stream y[n] = x[n] ^ y[n-39] ^ y[n-58], history newest at back.
   task automatic model_seed(input logic [57:0] s);
      hist.delete();
      for (int i = 57; i >= 0; i--) hist.push_back(s[i]);
   endtask

   function automatic logic [57:0] model_state();
      logic [57:0] st;
      for (int i = 0; i < 58; i++) st[i] = hist[57-i];
      return st;
   endfunction

   task automatic model_beat(input logic [31:0] d, input logic byp, output logic [31:0] r);
      logic y;
      r = d;
      if (!byp) begin
         for (int k = 31; k >= 0; k--) begin
            y    = d[k] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
            r[k] = y;
            hist.push_back(y);
            void'(hist.pop_front());
         end
      end
   endtask

   task automatic drive(input logic [31:0] d, input logic [1:0] h, input logic hv,
                        input logic byp, input logic ld);
      logic        acc;
      int          n;
      logic [31:0] r;
      i_valid = 1'b1; i_data = d; i_header = h; i_hdr_valid = hv;
      i_bypass = byp; i_seed_load = ld;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         #1;
         n++;
      end
      i_valid = 1'b0; i_bypass = 1'b0; i_seed_load = 1'b0;
      if (!acc) begin
         check("accept_timeout", 64'd0, 64'd1);
      end else begin
         model_beat(d, byp, r);
         exp_q.push_back({hv, h, r});
         if (loop_en) src_q.push_back({hv, h, d});
         if (ld) model_seed(i_seed);
         check("state", {6'd0, o_state}, {6'd0, model_state()});
      end
   endtask

   task automatic seed_pulse(input logic [57:0] s);
      i_seed = s; i_seed_load = 1'b1;
      @(posedge clk);
      #1;
      i_seed_load = 1'b0;
      model_seed(s);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || src_q.size() != 0) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", 64'(exp_q.size() + src_q.size()), 64'd0);
   endtask

   always @(posedge clk) begin
      #1;
      if (rand_tx) tb_ready = ($urandom_range(0, 1) == 1);
      if (rand_rx) rx_ready = ($urandom_range(0, 3) != 0);
   end

   // Occupancy model: beats held = accepted - taken; ready iff fewer than two are held.
   always @(negedge clk) begin
      if (mon_en) begin
         check("o_ready", 64'(o_ready), 64'(occ < 2));
         check("o_valid", 64'(o_valid), 64'(occ > 0));
         if (stall_prev)
            check("stall_hold", {o_valid, o_hdr_valid, o_header, o_data}, {1'b1, held});
         if (o_valid && tx_ready) begin
            if (exp_q.size() == 0) check("dup", 64'd1, 64'd0);
            else check("o_beat", {o_hdr_valid, o_header, o_data}, exp_q.pop_front());
         end
         occ = occ + ((i_valid && o_ready) ? 1 : 0) - ((o_valid && tx_ready) ? 1 : 0);
         stall_prev = o_valid && !tx_ready;
         held = {o_hdr_valid, o_header, o_data};
      end
   end

   always @(negedge clk) begin
      logic [34:0] s;
      if (loop_en && rx_o_valid && rx_ready) begin
         if (src_q.size() == 0) begin
            check("rx_dup", 64'd1, 64'd0);
         end else begin
            s = src_q.pop_front();
            check("rx_hdr", {rx_hv, rx_hdr}, s[34:32]);
            if (rx_idx >= 2) check("rx_data", rx_data, s[31:0]);
            rx_idx++;
         end
      end
   end

   initial begin
      logic [57:0] st;
      n_checks = 0; n_errors = 0; occ = 0; rx_idx = 0;
      mon_en = 0; stall_prev = 0; rand_tx = 0; rand_rx = 0; loop_en = 0;
      rst_n = 0; i_bypass = 0; i_seed_load = 0; i_seed = '0; i_valid = 0;
      i_data = '0; i_header = '0; i_hdr_valid = 0; tb_ready = 1;
      rx_seed_load = 0; rx_seed = '0; rx_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_ready", 64'(o_ready), 64'd1);
      check("rst_out", {o_hdr_valid, o_header, o_data}, 64'd0);
      check("rst_state", {6'd0, o_state}, {6'd0, SEED0});
      rst_n = 1;
      model_seed(SEED0);
      mon_en = 1;

      drive(32'h0, 2'b01, 1'b1, 1'b0, 1'b0);
      check("basic_d0", o_data, 64'h0);
      check("basic_s1", {6'd0, o_state}, 64'h3FF_FFFF_0000_0000);
      drive(32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
      check("basic_d1", o_data, 64'h01FF_FFC0);
      drain();

      seed_pulse(58'h0);
      check("seed_state", {6'd0, o_state}, 64'h0);
      drive(32'hFFFF_FFFF, 2'b01, 1'b1, 1'b0, 1'b0);
      check("seed_d", o_data, 64'hFFFF_FFFF);
      check("seed_s", {6'd0, o_state}, 64'h0000_0000_FFFF_FFFF);
      drain();

      drive($urandom, 2'b01, 1'b1, 1'b0, 1'b0);
      st = o_state;
      drive(32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1, 1'b0);
      check("byp_d", o_data, 64'hDEAD_BEEF);
      check("byp_s", {6'd0, o_state}, {6'd0, st});
      drive($urandom, 2'b10, 1'b0, 1'b0, 1'b0);
      drive($urandom, 2'b01, 1'b1, 1'b0, 1'b0);
      i_seed = 58'h123_4567_89AB_CDEF;
      drive($urandom, 2'b01, 1'b1, 1'b0, 1'b1);
      check("ld_beat_s", {6'd0, o_state}, 64'h123_4567_89AB_CDEF);
      drain();

      rand_tx = 1;
      for (int i = 0; i < 300; i++)
         drive($urandom, 2'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
      rand_tx = 0;
      tb_ready = 1;
      drain();

      rx_seed = '0; rx_seed_load = 1;
      @(posedge clk);
      #1;
      rx_seed_load = 0;
      check("rx_seed", {6'd0, rx_state}, 64'h0);
      loop_en = 1; rx_idx = 0; rand_rx = 1;
      for (int i = 0; i < 1000; i++)
         drive($urandom, 2'($urandom), 1'($urandom), 1'b0, 1'b0);
      rand_rx = 0;
      rx_ready = 1;
      drain();
      check("rx_count", 64'(rx_idx), 64'd1000);
      loop_en = 0;

      tb_ready = 0;
      drive($urandom, 2'b01, 1'b1, 1'b0, 1'b0);
      drive($urandom, 2'b10, 1'b0, 1'b0, 1'b0);
      check("skid_full_ready", 64'(o_ready), 64'd0);
      mon_en = 0;
      rst_n = 0;
      #1;
      check("async_valid", 64'(o_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1;
      check("post_rst_ready", 64'(o_ready), 64'd1);
      check("post_rst_state", {6'd0, o_state}, {6'd0, SEED0});
      check("post_rst_valid", 64'(o_valid), 64'd0);
      exp_q.delete();
      occ = 0; stall_prev = 0;
      model_seed(SEED0);
      tb_ready = 1;
      mon_en = 1;
      drive(32'h0, 2'b01, 1'b1, 1'b0, 1'b0);
      check("post_rst_d", o_data, 64'h0);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
